// File: rtl/vga_pkg.sv
// Types and defaults shared by the frame buffer and the VGA scan-out stage.
// Word layout: {2'b0, left pixel, 2'b0, right pixel}, pixel = {B[1:0],G[1:0],R[1:0]}.
package vga_pkg;

    localparam int MEM_WIDTH_DEF  = 32;
    localparam int MEM_HEIGHT_DEF = 24;

    typedef logic [5:0]  pixel_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        FILL
    } fill_state_t;

    function automatic word_t pack_pixels(pixel_t l, pixel_t r);
        return {2'b00, l, 2'b00, r};
    endfunction

endpackage

// File: rtl/vram_dp.sv
// Video RAM: port A write plus registered read (read-before-write), port B registered read.
// One-cycle read latency on both ports; no reset on the array or the read registers.
module vram_dp
    import vga_pkg::*;
#(
    parameter int DEPTH = 768,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we_a,
    input  logic [AW-1:0] waddr_a,
    input  logic [15:0]   wdata_a,
    input  logic [AW-1:0] raddr_a,
    output logic [15:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [15:0]   rdata_b
);

    word_t ram [DEPTH];

    // Port A read address is kept separate from its write address so the CPU
    // can keep reading while the fill engine owns the write side.
    always_ff @(posedge clock) begin
        if (we_a) begin
            ram[waddr_a] <= wdata_a;
        end
        rdata_a <= ram[raddr_a];
        rdata_b <= ram[raddr_b];
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// Frame buffer: CPU port A, scan-out port B, and a whole-buffer fill engine.
// Reads return one cycle later (zero when out of range); CPU writes are dropped while busy.
module vga_frame_buffer
    import vga_pkg::*;
#(
    parameter int          MEM_WIDTH       = MEM_WIDTH_DEF,
    parameter int          MEM_HEIGHT      = MEM_HEIGHT_DEF,
    parameter logic [15:0] MEM_ADDR_OFFSET = 16'h0000,
    parameter bit          FILL_IN_VBLANK  = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    input  logic        fill_start,
    input  logic [5:0]  fill_color,
    output logic        fill_done,
    input  logic [15:0] vga_addr,
    output logic [15:0] vga_data,
    input  logic        vga_vs
);

    localparam int            DEPTH = MEM_WIDTH * MEM_HEIGHT;
    localparam int            AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    logic [15:0] cpu_idx;
    logic [15:0] vga_idx;
    logic        cpu_ok;
    logic        vga_ok;
    logic        cpu_ok_q;
    logic        vga_ok_q;

    fill_state_t   state;
    fill_state_t   state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    pixel_t        color;
    pixel_t        color_nxt;
    logic          done_nxt;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_qa;
    logic [15:0]   ram_qb;

    // Addresses below the offset wrap to large values and fall out of range.
    assign cpu_idx = cpu_addr - MEM_ADDR_OFFSET;
    assign vga_idx = vga_addr - MEM_ADDR_OFFSET;
    assign cpu_ok  = {16'd0, cpu_idx} < 32'(DEPTH);
    assign vga_ok  = {16'd0, vga_idx} < 32'(DEPTH);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        color_nxt = color;
        done_nxt  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cpu_idx[AW-1:0];
        ram_wdata = cpu_wdata;
        case (state)
            IDLE: begin
                ram_we = cpu_we && cpu_ok;
                if (fill_start) begin
                    color_nxt = fill_color;
                    cnt_nxt   = '0;
                    state_nxt = FILL_IN_VBLANK ? WAIT_VB : FILL;
                end
            end
            WAIT_VB: begin
                if (!vga_vs) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = pack_pixels(color, color);
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A clear in the middle of a fill must not land one more word.
        if (clear) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            color     <= '0;
            fill_done <= 1'b0;
            cpu_ok_q  <= 1'b0;
            vga_ok_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            color     <= color_nxt;
            fill_done <= done_nxt;
            cpu_ok_q  <= cpu_ok;
            vga_ok_q  <= vga_ok;
        end
    end

    assign cpu_busy  = (state != IDLE);
    assign cpu_rdata = cpu_ok_q ? ram_qa : 16'h0000;
    assign vga_data  = vga_ok_q ? ram_qb : 16'h0000;

    vram_dp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_vram (
        .clock   (clock),
        .we_a    (ram_we),
        .waddr_a (ram_waddr),
        .wdata_a (ram_wdata),
        .raddr_a (cpu_idx[AW-1:0]),
        .rdata_a (ram_qa),
        .raddr_b (vga_idx[AW-1:0]),
        .rdata_b (ram_qb)
    );

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench: two frame buffers (immediate fill / fill in vertical blank) against an array model.
module tb_vga_frame_buffer;

    localparam int          DEPTH = 768;
    localparam logic [15:0] OFF   = 16'h0040;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear0, cpu_we0, cpu_busy0, fill_start0, fill_done0, vga_vs0;
    logic [15:0] cpu_addr0, cpu_wdata0, cpu_rdata0, vga_addr0, vga_data0;
    logic [5:0]  fill_color0;
    logic        clear1, cpu_we1, cpu_busy1, fill_start1, fill_done1, vga_vs1;
    logic [15:0] cpu_addr1, cpu_wdata1, cpu_rdata1, vga_addr1, vga_data1;
    logic [5:0]  fill_color1;

    logic [15:0] model0 [DEPTH];
    logic [15:0] model1 [DEPTH];
    logic [15:0] snap_c [DEPTH];
    logic [15:0] snap_v [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    vga_frame_buffer #(
        .MEM_WIDTH(32), .MEM_HEIGHT(24), .MEM_ADDR_OFFSET(OFF), .FILL_IN_VBLANK(1'b0)
    ) dut0 (
        .clock(clock), .clear(clear0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0),
        .cpu_wdata(cpu_wdata0), .cpu_rdata(cpu_rdata0), .cpu_busy(cpu_busy0),
        .fill_start(fill_start0), .fill_color(fill_color0), .fill_done(fill_done0),
        .vga_addr(vga_addr0), .vga_data(vga_data0), .vga_vs(vga_vs0)
    );

    vga_frame_buffer #(
        .MEM_WIDTH(32), .MEM_HEIGHT(24), .MEM_ADDR_OFFSET(OFF), .FILL_IN_VBLANK(1'b1)
    ) dut1 (
        .clock(clock), .clear(clear1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1),
        .cpu_wdata(cpu_wdata1), .cpu_rdata(cpu_rdata1), .cpu_busy(cpu_busy1),
        .fill_start(fill_start1), .fill_color(fill_color1), .fill_done(fill_done1),
        .vga_addr(vga_addr1), .vga_data(vga_data1), .vga_vs(vga_vs1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Word index for a bus address, or -1 when outside the buffer.
    function automatic int idx_of(input logic [15:0] a);
        int i;
        i = int'(a) - int'(OFF);
        return (i >= 0 && i < DEPTH) ? i : -1;
    endfunction

    function automatic logic [15:0] mread(input int d, input logic [15:0] a);
        int i;
        i = idx_of(a);
        if (i < 0) return 16'h0000;
        return (d == 0) ? model0[i] : model1[i];
    endfunction

    function automatic logic [15:0] fill_word(input logic [5:0] c);
        return 16'(int'(c) * 257);
    endfunction

    function automatic int snap_mism(input int d);
        int m;
        logic [15:0] e;
        m = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e = (d == 0) ? model0[i] : model1[i];
            if (snap_c[i] !== e || snap_v[i] !== e) m++;
        end
        return m;
    endfunction

    // Capture every word through both ports (port B walks the buffer backwards).
    task automatic scan(input int d);
        for (int i = 0; i < DEPTH; i++) begin
            if (d == 0) begin
                cpu_addr0 = OFF + 16'(i);
                vga_addr0 = OFF + 16'(DEPTH - 1 - i);
            end else begin
                cpu_addr1 = OFF + 16'(i);
                vga_addr1 = OFF + 16'(DEPTH - 1 - i);
            end
            tick();
            snap_c[i]             = (d == 0) ? cpu_rdata0 : cpu_rdata1;
            snap_v[DEPTH - 1 - i] = (d == 0) ? vga_data0  : vga_data1;
        end
    endtask

    task automatic test_reset();
        clear0 = 1'b1; clear1 = 1'b1;
        fill_start0 = 1'b1; fill_start1 = 1'b1;
        cpu_addr0 = OFF; vga_addr0 = OFF; cpu_addr1 = OFF; vga_addr1 = OFF;
        tick(); tick();
        fill_start0 = 1'b0; fill_start1 = 1'b0;
        n_checks++; if (cpu_rdata0 !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected 0000", cpu_rdata0); end
        n_checks++; if (vga_data0 !== 16'h0) begin n_fail++; $display("FAIL reset_vga_data: got %h expected 0000", vga_data0); end
        n_checks++; if (cpu_busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", cpu_busy0); end
        n_checks++; if (fill_done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", fill_done0); end
        n_checks++;
        if ({cpu_rdata1, vga_data1, cpu_busy1, fill_done1} !== 34'h0) begin
            n_fail++; $display("FAIL reset_dut1: got %h expected 0", {cpu_rdata1, vga_data1, cpu_busy1, fill_done1});
        end
        clear0 = 1'b0; clear1 = 1'b0;
        tick();
        n_checks++; if (cpu_busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b expected 0", cpu_busy0); end
        // Give every word a known random value.
        for (int i = 0; i < DEPTH; i++) begin
            cpu_we0 = 1'b1; cpu_addr0 = OFF + 16'(i); cpu_wdata0 = 16'($urandom); model0[i] = cpu_wdata0;
            cpu_we1 = 1'b1; cpu_addr1 = OFF + 16'(i); cpu_wdata1 = 16'($urandom); model1[i] = cpu_wdata1;
            tick();
        end
        cpu_we0 = 1'b0; cpu_we1 = 1'b0;
    endtask

    task automatic test_basic_rw();
        cpu_we0 = 1'b1; cpu_addr0 = OFF + 16'd5; cpu_wdata0 = 16'h2A15;
        tick();
        model0[5] = 16'h2A15;
        cpu_we0 = 1'b0; vga_addr0 = OFF + 16'd5;
        tick();
        n_checks++; if (vga_data0 !== 16'h2A15) begin n_fail++; $display("FAIL basic_vga: got %h expected 2a15", vga_data0); end
        n_checks++; if (cpu_rdata0 !== 16'h2A15) begin n_fail++; $display("FAIL basic_cpu: got %h expected 2a15", cpu_rdata0); end
    endtask

    task automatic test_random_rw();
        logic [15:0] exp_c, exp_v;
        int i;
        for (int n = 0; n < 300; n++) begin
            cpu_we0    = 1'($urandom_range(0, 1));
            cpu_wdata0 = 16'($urandom);
            cpu_addr0  = OFF + 16'($urandom_range(0, DEPTH + 3)) - 16'd2;
            vga_addr0  = ($urandom_range(0, 3) == 0) ? cpu_addr0
                                                     : OFF + 16'($urandom_range(0, DEPTH + 3)) - 16'd2;
            exp_c = mread(0, cpu_addr0);
            exp_v = mread(0, vga_addr0);
            tick();
            i = idx_of(cpu_addr0);
            if (cpu_we0 && i >= 0) model0[i] = cpu_wdata0;
            n_checks++; if (cpu_rdata0 !== exp_c) begin n_fail++; $display("FAIL rand_cpu @%h: got %h expected %h", cpu_addr0, cpu_rdata0, exp_c); end
            n_checks++; if (vga_data0 !== exp_v) begin n_fail++; $display("FAIL rand_vga @%h: got %h expected %h", vga_addr0, vga_data0, exp_v); end
        end
        cpu_we0 = 1'b0;
    endtask

    task automatic test_fill();
        int first_busy, busy_cnt, done_tick, done_cnt, m;
        logic busy_at_done;
        first_busy = -1; busy_cnt = 0; done_tick = -1; done_cnt = 0; busy_at_done = 1'b1;
        cpu_addr0 = OFF + 16'd700; cpu_wdata0 = 16'h0101;
        fill_start0 = 1'b1; fill_color0 = 6'h3F;
        for (int k = 1; k <= 900; k++) begin
            tick();
            if (cpu_busy0 === 1'b1) begin busy_cnt++; if (first_busy < 0) first_busy = k; end
            if (fill_done0 === 1'b1) begin
                done_cnt++;
                if (done_tick < 0) begin done_tick = k; busy_at_done = cpu_busy0; end
            end
            // Word 700 is filled by edge 702; the CPU write at 750 must not overwrite it.
            cpu_we0     = (k + 1 == 750);
            fill_start0 = (k + 1 == 400);
            fill_color0 = (k + 1 == 400) ? 6'h15 : 6'h3F;
        end
        cpu_we0 = 1'b0; fill_start0 = 1'b0;
        n_checks++; if (first_busy != 1) begin n_fail++; $display("FAIL fill_first_busy: got %0d expected 1", first_busy); end
        n_checks++; if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d expected %0d", busy_cnt, DEPTH); end
        n_checks++; if (done_tick != DEPTH + 1) begin n_fail++; $display("FAIL fill_done_cycle: got %0d expected %0d", done_tick, DEPTH + 1); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL fill_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL fill_busy_at_done: got %b expected 0", busy_at_done); end
        for (int i = 0; i < DEPTH; i++) model0[i] = 16'h3F3F;
        scan(0);
        n_checks++; if (snap_c[700] !== 16'h3F3F) begin n_fail++; $display("FAIL fill_word700: got %h expected 3f3f", snap_c[700]); end
        m = snap_mism(0);
        n_checks++; if (m != 0) begin n_fail++; $display("FAIL fill_scan: got %0d bad words expected 0", m); end
    endtask

    task automatic test_clear_mid_fill();
        logic [5:0]  c;
        logic [15:0] fw;
        int done_cnt, busy_cnt, m;
        c  = 6'($urandom_range(0, 62));
        fw = fill_word(c);
        fill_start0 = 1'b1; fill_color0 = c;
        for (int k = 1; k <= 101; k++) begin
            tick();
            fill_start0 = 1'b0;
        end
        clear0 = 1'b1;
        tick();
        n_checks++; if (cpu_busy0 !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b expected 0", cpu_busy0); end
        n_checks++; if (fill_done0 !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %b expected 0", fill_done0); end
        clear0 = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (fill_done0 === 1'b1) done_cnt++;
            if (cpu_busy0 === 1'b1) busy_cnt++;
        end
        n_checks++; if (done_cnt + busy_cnt != 0) begin n_fail++; $display("FAIL clear_quiet: got %0d done/%0d busy expected 0/0", done_cnt, busy_cnt); end
        for (int i = 0; i < 100; i++) model0[i] = fw;
        scan(0);
        n_checks++; if (snap_c[99] !== fw) begin n_fail++; $display("FAIL clear_word99: got %h expected %h", snap_c[99], fw); end
        n_checks++; if (snap_c[100] !== 16'h3F3F) begin n_fail++; $display("FAIL clear_word100: got %h expected 3f3f", snap_c[100]); end
        m = snap_mism(0);
        n_checks++; if (m != 0) begin n_fail++; $display("FAIL clear_scan: got %0d bad words expected 0", m); end
    endtask

    task automatic test_invalid();
        logic [15:0] bad [6];
        int m;
        bad[0] = OFF + 16'(DEPTH); bad[1] = OFF - 16'd1;  bad[2] = 16'hFFFF;
        bad[3] = OFF + 16'd1029;   bad[4] = 16'h0000;     bad[5] = OFF - 16'd1024;
        for (int j = 0; j < 6; j++) begin
            model0[3] = 16'h8000 | 16'($urandom);
            cpu_we0 = 1'b1; cpu_addr0 = OFF + 16'd3; cpu_wdata0 = model0[3];
            tick();
            cpu_we0 = 1'b0; vga_addr0 = OFF + 16'd3;
            tick();
            cpu_addr0 = bad[j]; vga_addr0 = bad[j];
            tick();
            n_checks++; if (cpu_rdata0 !== 16'h0) begin n_fail++; $display("FAIL invalid_cpu @%h: got %h expected 0000", bad[j], cpu_rdata0); end
            n_checks++; if (vga_data0 !== 16'h0) begin n_fail++; $display("FAIL invalid_vga @%h: got %h expected 0000", bad[j], vga_data0); end
            cpu_we0 = 1'b1; cpu_wdata0 = 16'($urandom);
            tick();
            cpu_we0 = 1'b0;
        end
        scan(0);
        m = snap_mism(0);
        n_checks++; if (m != 0) begin n_fail++; $display("FAIL invalid_write_scan: got %0d bad words expected 0", m); end
    endtask

    task automatic test_vblank_fill();
        logic [5:0]  c;
        logic [15:0] fw, old0, nw;
        int busy_cnt, stale_bad, m;
        logic got_done;
        c  = 6'($urandom);
        fw = fill_word(c);
        old0 = model1[0];
        if (old0 == fw) begin c = c ^ 6'h01; fw = fill_word(c); end
        vga_vs1 = 1'b1; vga_addr1 = OFF; cpu_addr1 = OFF; cpu_wdata1 = ~old0;
        fill_start1 = 1'b1; fill_color1 = c;
        tick();
        fill_start1 = 1'b0;
        busy_cnt = 0; stale_bad = 0;
        for (int k = 0; k < 50; k++) begin
            cpu_we1 = (k == 20);
            if (cpu_busy1 === 1'b1) busy_cnt++;
            if (vga_data1 !== old0) stale_bad++;
            tick();
        end
        cpu_we1 = 1'b0;
        n_checks++; if (busy_cnt != 50) begin n_fail++; $display("FAIL vb_wait_busy: got %0d expected 50", busy_cnt); end
        n_checks++; if (stale_bad != 0) begin n_fail++; $display("FAIL vb_wait_nowrite: got %0d changed reads expected 0", stale_bad); end
        vga_vs1 = 1'b0;
        tick();
        vga_vs1 = 1'b1;
        n_checks++; if (vga_data1 !== old0) begin n_fail++; $display("FAIL vb_pre_write: got %h expected %h", vga_data1, old0); end
        tick();
        n_checks++; if (vga_data1 !== old0) begin n_fail++; $display("FAIL vb_collide_write: got %h expected %h", vga_data1, old0); end
        tick();
        n_checks++; if (vga_data1 !== fw) begin n_fail++; $display("FAIL vb_first_write: got %h expected %h", vga_data1, fw); end
        got_done = 1'b0;
        for (int k = 0; k < 1000 && !got_done; k++) begin
            tick();
            if (fill_done1 === 1'b1) got_done = 1'b1;
        end
        n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL vb_done_timeout: got %b expected 1", got_done); end
        for (int i = 0; i < DEPTH; i++) model1[i] = fw;
        scan(1);
        m = snap_mism(1);
        n_checks++; if (m != 0) begin n_fail++; $display("FAIL vb_scan: got %0d bad words expected 0", m); end
        // Port A write and port B read of the same word in one cycle.
        nw = ~model1[0];
        cpu_we1 = 1'b1; cpu_addr1 = OFF; cpu_wdata1 = nw; vga_addr1 = OFF;
        tick();
        cpu_we1 = 1'b0;
        n_checks++; if (vga_data1 !== fw) begin n_fail++; $display("FAIL collide_vga_old: got %h expected %h", vga_data1, fw); end
        n_checks++; if (cpu_rdata1 !== fw) begin n_fail++; $display("FAIL collide_cpu_old: got %h expected %h", cpu_rdata1, fw); end
        tick();
        model1[0] = nw;
        n_checks++; if (vga_data1 !== nw) begin n_fail++; $display("FAIL collide_vga_new: got %h expected %h", vga_data1, nw); end
    endtask

    initial begin
        clear0 = 1'b1; cpu_we0 = 1'b0; cpu_addr0 = '0; cpu_wdata0 = '0; fill_start0 = 1'b0;
        fill_color0 = '0; vga_addr0 = '0; vga_vs0 = 1'b1;
        clear1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = '0; cpu_wdata1 = '0; fill_start1 = 1'b0;
        fill_color1 = '0; vga_addr1 = '0; vga_vs1 = 1'b1;
        test_reset();
        test_basic_rw();
        test_random_rw();
        test_fill();
        test_clear_mid_fill();
        test_invalid();
        test_vblank_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
